hqm_aw_ready_break_buffer: RTL and testbench
============================================

// Module: hqm_AW_ready_break_buffer
// PURPOSE
// - Ready/valid stage that registers only the backward (ready) path: out_ready -> in_ready timing is broken by one flop.
// - Forward valid/data stays combinational (0-cycle latency when not stalled).
// - Complements the forward-registered stages; pinout and status format match the AW buffer family, so instances swap in unchanged.
// - Sits between pipeline stages whose ready fan-in is timing critical.
// PARAMETERS
// - WIDTH             32  payload width
// - NOT_EMPTY_AT_EOT  0   1 = skid entry may legally hold data at end of test (sim-only check disabled)
// PORTS
// - clk        in   1      clock (single clock domain)
// - rst_n      in   1      asynchronous active-low reset
// - status     out  7      {err, 3'b0, out_ready, skid_valid, out_valid}
// - in_ready   out  1      registered; =~skid_valid
// - in_valid   in   1      upstream valid
// - in_data    in   WIDTH  upstream payload
// - out_ready  in   1      downstream ready
// - out_valid  out  1      in_valid | skid_valid
// - out_data   out  WIDTH  skid_valid ? skid_data : in_data
// BEHAVIOUR
// - State: one skid entry (skid_valid, skid_data[WIDTH-1:0]); EMPTY (skid_valid=0) / FULL (skid_valid=1).
// - Reset (async, rst_n=0): skid_valid=0, skid_data='0, err=0 -> in_ready=1; out_valid/out_data follow in_* combinationally.
// - EMPTY: in->out passthrough, in_ready=1. in_valid & ~out_ready -> capture in_data into skid, go FULL next edge.
// - EMPTY, in_valid & out_ready: transfer same cycle, stay EMPTY.
// - FULL: in_ready=0, out_data=skid_data, out_valid=1; out_ready -> go EMPTY next edge; in_* not accepted this cycle.
// - FULL & ~out_ready: hold skid_data unchanged.
// - Never capture and drain in the same cycle (in_ready=0 whenever FULL); max throughput 1/clk when unstalled.
// - Ordering: skid entry always drains before any new input word; no reorder, no drop, no duplicate.
// - Reset mid-operation: skid contents discarded; no output glitch beyond combinational in_* follow.
// - Upstream must hold in_valid/in_data stable while in_valid & ~in_ready (AXI-style rule).
// - status[1]=skid_valid (depth), status[0]=out_valid, status[2]=out_ready, status[5:3]=0.
// CONFIGURATION
// - Macro HQM_AW_READY_BREAK_BUFFER_PROTOCOL_CHK_EN:
//   - Defined: sticky err flop; set when prior cycle had in_valid & ~in_ready and current cycle drops in_valid or changes in_data.
//     Cleared only by rst_n. status[6]=err.
//   - Not defined: no checker logic, status[6]=1'b0.
// STRUCTURE
// - hqm_AW_pkg: localparams HQM_AW_BUF_STATUS_ERR_BIT=6, _ORDY_BIT=2, _DEPTH_BIT=1, _VLD_BIT=0; shared with other AW buffers.
// - Sub-module hqm_AW_rv_protocol_chk (WIDTH param): holds the macro-gated checker; instantiated only under the macro.
// - Datapath: single always_ff for skid flops, continuous assigns for outputs.
// - Sim-only final block: if !NOT_EMPTY_AT_EOT and skid_valid at EOT -> $error.
// TESTING
// - Reset: rst_n=0 with in_valid=1,in_data=0xA5 -> in_ready=1, out_valid=1, out_data=0xA5, status=7'b0000001 (out_ready=0).
// - Passthrough: out_ready=1, 8 back-to-back words 0..7 -> out_data 0..7 same cycles, skid_valid stays 0.
// - Stall capture: in 0x11 with out_ready=0 -> next cycle in_ready=0, out_data=0x11, status[1]=1;
//   out_ready=1 -> 0x11 drained, in_ready=1 following cycle.
// - Random ready: out_ready toggled randomly (50%), 1000 words -> scoreboard in-order, no loss/dup.
// - Reset while FULL (skid=0x22) -> skid dropped, in_ready=1 immediately; 0x22 never appears after reset.
// - Macro on: drop in_valid while in_ready=0 -> status[6]=1 next cycle and stays 1 until reset.
//   Macro off: same stimulus -> status[6]=0.

Source files
------------

// File: rtl/hqm_aw_ready_break_buffer_pkg.sv
// hqm_aw_ready_break_buffer_pkg: status bit layout shared by the AW buffer family
// Contents: status word width and bit positions for err, out_ready, depth and valid.
package hqm_aw_ready_break_buffer_pkg;
    localparam int HQM_AW_BUF_STATUS_W         = 7;
    localparam int HQM_AW_BUF_STATUS_ERR_BIT   = 6;
    localparam int HQM_AW_BUF_STATUS_ORDY_BIT  = 2;
    localparam int HQM_AW_BUF_STATUS_DEPTH_BIT = 1;
    localparam int HQM_AW_BUF_STATUS_VLD_BIT   = 0;
endpackage

// File: rtl/hqm_aw_ready_break_buffer_protocol_chk.sv
// hqm_aw_ready_break_buffer_protocol_chk: sticky checker for upstream valid/data stability while stalled
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_data observed, err sticky flag out.
module hqm_aw_ready_break_buffer_protocol_chk #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             err
);
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
            prev_data  <= '0;
            err        <= 1'b0;
        end else begin
            prev_stall <= in_valid & ~in_ready;
            prev_data  <= in_data;
            // a stalled word must stay presented with identical payload until taken
            err        <= err | (prev_stall & (~in_valid | (in_data != prev_data)));
        end
    end
endmodule

// File: rtl/hqm_aw_ready_break_buffer.sv
// hqm_aw_ready_break_buffer: ready/valid stage registering only the backward (ready) path via one skid entry
// Ports: clk, rst_n (async active-low), status {err,3'b0,out_ready,skid_valid,out_valid},
//        in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
// Macro HQM_AW_READY_BREAK_BUFFER_PROTOCOL_CHK_EN enables the sticky upstream protocol checker (status[6]).
module hqm_aw_ready_break_buffer
    import hqm_aw_ready_break_buffer_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter bit          NOT_EMPTY_AT_EOT = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic [HQM_AW_BUF_STATUS_W-1:0] status,
    output logic                           in_ready,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data
);
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             err;
    // capture only when empty and downstream stalls; drain only when full and downstream ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!skid_valid) begin
            skid_valid <= in_valid & ~out_ready;
            if (in_valid & ~out_ready) skid_data <= in_data;
        end else if (out_ready) begin
            skid_valid <= 1'b0;
        end
    end
    assign in_ready  = ~skid_valid;
    assign out_valid = in_valid | skid_valid;
    assign out_data  = skid_valid ? skid_data : in_data;
`ifdef HQM_AW_READY_BREAK_BUFFER_PROTOCOL_CHK_EN
    hqm_aw_ready_break_buffer_protocol_chk #(.WIDTH(WIDTH)) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .err      (err)
    );
`else
    assign err = 1'b0;
`endif
    always_comb begin
        status                              = '0;
        status[HQM_AW_BUF_STATUS_ERR_BIT]   = err;
        status[HQM_AW_BUF_STATUS_ORDY_BIT]  = out_ready;
        status[HQM_AW_BUF_STATUS_DEPTH_BIT] = skid_valid;
        status[HQM_AW_BUF_STATUS_VLD_BIT]   = out_valid;
    end
    final begin
        if (!NOT_EMPTY_AT_EOT && skid_valid) $error("hqm_aw_ready_break_buffer: skid entry occupied at end of test");
    end
endmodule

// File: tb/tb_hqm_aw_ready_break_buffer.sv
// tb_hqm_aw_ready_break_buffer: directed + random self-checking bench against a queue-based reference model
module tb_hqm_aw_ready_break_buffer;
    logic        clk;
    logic        rst_n;
    logic [6:0]  status;
    logic        in_ready;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    int          total = 0;
    int          bad = 0;
    logic [31:0] q[$];
    int          delivered;
    bit          accepted;
`ifdef HQM_AW_READY_BREAK_BUFFER_PROTOCOL_CHK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif
    hqm_aw_ready_break_buffer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .status    (status),
        .in_ready  (in_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Model: q holds words accepted but not yet delivered; the buffer can hold at most one.
    task automatic model();
        logic        exp_vld;
        logic [31:0] exp_dat;
        exp_vld = in_valid || (q.size() > 0);
        exp_dat = (q.size() > 0) ? q[0] : in_data;
        chk("in_ready", in_ready, q.size() == 0);
        chk("out_valid", out_valid, exp_vld);
        chk("depth", status[1], q.size() > 0);
        chk("ordy", status[2], out_ready);
        chk("status_zero", status[5:3], 3'b000);
        if (exp_vld) chk("out_data", out_data, exp_dat);
        accepted = in_valid && (q.size() == 0);
        if (accepted) q.push_back(in_data);
        if (exp_vld && out_ready) begin
            void'(q.pop_front());
            delivered++;
        end
    endtask
    task automatic cyc();
        @(negedge clk);
        model();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int cycles;
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA5;
        out_ready = 1'b0;
        delivered = 0;
        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b1);
        chk("rst_out_data", out_data, 32'hA5);
        chk("rst_status", status, 7'b0000001);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = i;
            @(negedge clk);
            chk("pass_data", out_data, i);
            chk("pass_skid", status[1], 1'b0);
            model();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data = 32'h11;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_out_data", out_data, 32'h11);
        chk("stall_depth", status[1], 1'b1);
        model();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("drain_in_ready", in_ready, 1'b1);
        model();
        @(posedge clk);
        #1;
        delivered = 0;
        cycles = 0;
        in_valid = 1'b0;
        accepted = 1'b0;
        while (delivered < 1000 && cycles < 20000) begin
            if (!(in_valid && !accepted)) begin
                in_valid = ($urandom_range(3) != 0);
                in_data = $urandom;
            end
            out_ready = $urandom_range(1);
            cyc();
            cycles++;
        end
        chk("rand_budget", cycles < 20000, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("rand_empty", q.size(), 0);
        in_valid = 1'b1;
        in_data = 32'h22;
        out_ready = 1'b0;
        cyc();
        chk("full_before_rst", status[1], 1'b1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_full_in_ready", in_ready, 1'b1);
        chk("rst_full_depth", status[1], 1'b0);
        chk("rst_full_out_valid", out_valid, 1'b0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h33;
        @(negedge clk);
        chk("post_rst_data", out_data, 32'h33);
        model();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc();
        cyc();
        in_valid = 1'b1;
        in_data = 32'h44;
        out_ready = 1'b0;
        cyc();
        in_data = 32'h55;
        cyc();
        chk("pre_violation_err", status[6], 1'b0);
        in_valid = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_sticky", status[6], EXP_ERR);
            model();
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        chk("final_empty", q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("err_cleared", status[6], 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("err_after_rst", status[6], 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
